// File: rtl/rop3_blit_ctrl.sv
// Rectangle sequencer for a ROP3 datapath: issues S/D reads in raster order and
// writes each ROP3 result back to the destination once the datapath latency has elapsed.
module rop3_blit_ctrl #(
    parameter int unsigned N       = 8,
    parameter int unsigned AW      = 16,
    parameter int unsigned ROP_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    mode_in,
    input  logic [N-1:0]  pat_in,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [7:0]    width,
    input  logic [7:0]    height,
    input  logic [AW-1:0] stride,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          src_rd_en,
    output logic [AW-1:0] src_addr,
    input  logic [N-1:0]  src_rdata,
    output logic          dst_rd_en,
    output logic [AW-1:0] dst_addr,
    input  logic [N-1:0]  dst_rdata,
    output logic [N-1:0]  rop_P,
    output logic [N-1:0]  rop_S,
    output logic [N-1:0]  rop_D,
    output logic [7:0]    rop_Mode,
    input  logic [N-1:0]  rop_Result,
    output logic          dst_wr_en,
    output logic [AW-1:0] dst_wr_addr,
    output logic [N-1:0]  dst_wdata
);

    localparam int unsigned DIM_W = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;

    logic [DIM_W-1:0] w_m1;
    logic [DIM_W-1:0] h_m1;
    logic [DIM_W-1:0] x;
    logic [DIM_W-1:0] y;
    logic [AW-1:0]    stride_q;
    logic [AW-1:0]    src_row;
    logic [AW-1:0]    dst_row;

    // Valid bit and write address per in-flight pixel; stage ROP_LAT drives the write port.
    logic [ROP_LAT:0] vld;
    logic [AW-1:0]    wa [ROP_LAT+1];

    logic issue_c;
    logic row_end_c;
    logic last_px_c;
    logic pending_c;

    assign issue_c   = (state == S_RUN) && !hold;
    assign row_end_c = (x == w_m1);
    assign last_px_c = row_end_c && (y == h_m1);
    // Anything still in flight other than the pixel being written this cycle.
    assign pending_c = |vld[ROP_LAT-1:0];

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if ((width == '0) || (height == '0)) state_nxt = S_DONE;
                    else                                 state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (issue_c && last_px_c) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!pending_c) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Command latch and incremental address walk (row-start registers, no multiply).
    always_ff @(posedge clk) begin
        if (rst) begin
            rop_Mode <= '0;
            rop_P    <= '0;
            w_m1     <= '0;
            h_m1     <= '0;
            x        <= '0;
            y        <= '0;
            stride_q <= '0;
            src_row  <= '0;
            dst_row  <= '0;
            src_addr <= '0;
            dst_addr <= '0;
        end else if ((state == S_IDLE) && start) begin
            rop_Mode <= mode_in;
            rop_P    <= pat_in;
            w_m1     <= width - DIM_W'(1);
            h_m1     <= height - DIM_W'(1);
            x        <= '0;
            y        <= '0;
            stride_q <= stride;
            src_row  <= src_base;
            dst_row  <= dst_base;
            src_addr <= src_base;
            dst_addr <= dst_base;
        end else if (issue_c) begin
            if (row_end_c) begin
                x        <= '0;
                y        <= y + DIM_W'(1);
                src_row  <= src_row + stride_q;
                dst_row  <= dst_row + stride_q;
                src_addr <= src_row + stride_q;
                dst_addr <= dst_row + stride_q;
            end else begin
                x        <= x + DIM_W'(1);
                src_addr <= src_addr + AW'(1);
                dst_addr <= dst_addr + AW'(1);
            end
        end
    end

    // Latency-matching shift chain; reset drops every in-flight pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i <= int'(ROP_LAT); i++) wa[i] <= '0;
        end else begin
            vld   <= {vld[ROP_LAT-1:0], issue_c};
            wa[0] <= issue_c ? dst_addr : '0;
            for (int i = 1; i <= int'(ROP_LAT); i++) wa[i] <= wa[i-1];
        end
    end

    assign src_rd_en   = issue_c;
    assign dst_rd_en   = issue_c;
    assign rop_S       = src_rdata;
    assign rop_D       = dst_rdata;
    assign dst_wr_en   = vld[ROP_LAT];
    assign dst_wr_addr = wa[ROP_LAT];
    assign dst_wdata   = vld[ROP_LAT] ? rop_Result : '0;

endmodule

// File: doc/rop3_blit_ctrl.md
# rop3_blit_ctrl

Sequencer that runs one ROP3 raster operation over a W×H rectangle: walks source and destination addresses, feeds S/D pixel pairs plus a fixed pattern and mode into an external `rop3_*` datapath instance (`rop3_smart` or `rop3_lut256`), and writes each result back to the destination buffer. It sits between the host command interface and the memories/ROP3 unit, hiding the ROP3 pipeline latency with a valid/address shift chain.

## Interface
- `N`, 8, pixel width (matches ROP3 `N`)
- `AW`, 16, memory address width
- `ROP_LAT`, 2, ROP3 input-to-`Result` latency in cycles
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  command strobe, sampled only in IDLE
- `mode_in`  in  8  ROP3 mode, latched at start
- `pat_in`  in  N  pattern P, latched at start
- `src_base` / `dst_base`  in  AW  top-left addresses, latched at start
- `width` / `height`  in  8  rectangle size in pixels, latched at start
- `stride`  in  AW  row pitch for both buffers, latched at start
- `hold`  in  1  pause issue of new pixels
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle completion pulse
- `src_rd_en` / `src_addr`  out  1 / AW  source read; `src_rdata` valid next cycle
- `src_rdata`  in  N  source read data
- `dst_rd_en` / `dst_addr`  out  1 / AW  destination read; `dst_rdata` valid next cycle
- `dst_rdata`  in  N  destination read data
- `rop_P`, `rop_S`, `rop_D`  out  N  ROP3 operands
- `rop_Mode`  out  8  ROP3 mode
- `rop_Result`  in  N  ROP3 output
- `dst_wr_en` / `dst_wr_addr` / `dst_wdata`  out  1 / AW / N  destination write

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on `start`=1, latch all command inputs. If `width`=0 or `height`=0, go to DONE; else go to RUN with x=0, y=0.
- RUN: each cycle with `hold`=0, issue pixel (x,y): `src_rd_en`=`dst_rd_en`=1, `src_addr`=src_base+y·stride+x, `dst_addr`=dst_base+y·stride+x, computed incrementally with row-start registers, no multiplier. Advance x; at x=width−1, set x=0 and y+1. After issuing pixel (width−1,height−1), go to DRAIN. With `hold`=1, issue nothing; in-flight pixels keep moving.
- `rop_S`=`src_rdata`, `rop_D`=`dst_rdata` (pass-through). `rop_P`, `rop_Mode` hold latched values from start until the next start.
- A (1+ROP_LAT)-deep shift chain carries the valid bit and dst address for each issued pixel. Its output drives `dst_wr_en`/`dst_wr_addr`; `dst_wdata`=`rop_Result`.
- DRAIN: stay until the shift chain is empty, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` in RUN, DRAIN or DONE is ignored; no queueing.
- Addresses wrap modulo 2^AW.
- Each pixel is read exactly once and written exactly once, in raster order.

## Timing
- Reset: state=IDLE, shift chain cleared. All outputs are 0: `busy`, `done`, read/write enables, addresses, `dst_wdata`, `rop_P`, `rop_Mode`.
- `rst` mid-operation aborts the operation: no further reads or writes from the next cycle, and no `done`.
- `start` sampled at edge E0 → `busy`=1 and first read issued in cycle E0+1.
- Pixel issued in cycle t → written in cycle t+1+ROP_LAT (t+3 by default).
- Without hold, W·H pixels issue in W·H consecutive cycles.
- `done` is asserted in the cycle after the final write. `busy` falls in the same cycle `done` rises.
- Zero-size command: `done` in cycle E0+1 with no reads or writes; `busy` stays 0.
- `hold` takes effect in the cycle it is sampled high: no read that cycle. `hold` is ignored outside RUN.
- A new `start` is accepted at the earliest in the cycle after `done`.

## Test plan
- 2×2, src_base=0x0010, dst_base=0x0100, stride=4, mode=0xCC (copy S):
  - reads at 0x10, 0x11, 0x14, 0x15;
  - writes dst[0x100, 0x101, 0x104, 0x105] = src values, each 3 cycles after its read;
  - `done` in cycle 8 after the start edge.
- 3×1, mode=0xF0, pat=0xA5 → three writes of 0xA5. mode=0x5A → each write = 0xA5 ^ dst_old.
- width=0, height=5 → `done` 1 cycle after start; zero read or write enables.
- 4×1 with `hold`=1 for 2 cycles after the second issue → 4 writes in order with a 2-cycle gap; `done` delayed by 2 cycles.
- `rst` pulsed in the cycle after the 3rd issue of a 4×4 job → no writes from the next cycle, `busy`=0, no `done`; a following 1×1 job completes normally.
- `start` pulsed while `busy` → ignored, latched parameters unchanged.
- dst_base=0xFFFF, 2×1 → second address wraps to 0x0000.
